fsmotor_stepgen: RTL and testbench
==================================

# fsmotor_stepgen

Multi-channel stepper pulse generator that replaces the plain motor-signal passthrough with on-chip step generation. Each channel accepts a move command (step count, step period, direction), produces a registered drive/dir pulse train, and reports busy, done and steps remaining. The block sits between the motor-control register file and the motor driver pins. It keeps microstep, enable, reset and zero-position signals per channel.

## Interface
- C_CH_NUM, 6, number of independent motor channels (1..16)
- C_MICROSTEP_WIDTH, 3, microstep select width per channel
- C_STEP_WIDTH, 16, step-count width per channel
- C_SPEED_WIDTH, 16, step-period width per channel, in clk cycles
- C_INVERT_DIR, 0, nonzero inverts m_dir relative to the logical direction

Ports (per-channel buses are flattened; channel i occupies slice i):
- clk  in  1  block clock
- rst  in  1  asynchronous, active-high reset
- s_start  in  C_CH_NUM  1-cycle move request
- s_stop  in  C_CH_NUM  1-cycle abort request
- s_dir  in  C_CH_NUM  logical direction (1 = away from zero, 0 = toward zero)
- s_steps  in  C_CH_NUM*C_STEP_WIDTH  step count for the move
- s_period  in  C_CH_NUM*C_SPEED_WIDTH  clocks per step
- s_ms  in  C_CH_NUM*C_MICROSTEP_WIDTH  microstep select, passed through
- s_xen, s_xrst  in  C_CH_NUM each  driver enable and reset, passed through
- s_busy  out  C_CH_NUM  move in progress
- s_done  out  C_CH_NUM  1-cycle move-finished pulse
- s_zhit  out  C_CH_NUM  last move ended on zero-position detect
- s_remain  out  C_CH_NUM*C_STEP_WIDTH  steps not yet issued
- s_zpd  out  C_CH_NUM  synchronised zero-position detect
- m_zpd  in  C_CH_NUM  raw zero-position sensor, asynchronous
- m_ms  out  C_CH_NUM*C_MICROSTEP_WIDTH  equals s_ms, combinational
- m_xen, m_xrst  out  C_CH_NUM each  equal s_xen and s_xrst, combinational
- m_drive, m_dir  out  C_CH_NUM each  registered step and direction outputs

## Operation
- Channels are fully independent. One FSM per channel: IDLE, SETUP, RUN.
- Reset values:
  - all states IDLE
  - s_busy, s_done, s_zhit, m_drive = 0
  - s_remain = 0
  - m_dir = C_INVERT_DIR ? 1 : 0
  - synchroniser flops = 0
- IDLE:
  - s_start with s_steps != 0: latch steps, period and dir, then go to SETUP. m_dir takes the latched dir, XOR-inverted when C_INVERT_DIR is set.
  - s_start with s_steps == 0 is ignored, with no done pulse.
- SETUP lasts one cycle with m_drive = 0 (direction setup time), then goes to RUN with the step counter cnt = 0.
- RUN:
  - Each step is P cycles, where P = max(latched period, 2).
  - m_drive = 1 while cnt < P>>1, else 0.
  - cnt counts 0..P-1 and wraps. On wrap, s_remain decrements.
  - When s_remain reaches 0, or a stop is pending, the channel goes to IDLE with s_done = 1 for one cycle.
- s_busy = 1 in SETUP and RUN.
- s_start while busy is ignored; the latched parameters are never changed mid-move.
- s_stop:
  - In RUN: sets a pending flag. The current step finishes (no truncated pulse), then the channel ends the move with s_remain holding the unissued count.
  - In SETUP: returns to IDLE with s_done, no pulse, s_remain unchanged.
  - In IDLE: ignored.
- s_start and s_stop in the same IDLE cycle: start wins and stop is ignored.
- s_zhit is cleared on every accepted start.
- m_zpd passes through a 2-flop synchroniser to s_zpd.
- Width rules:
  - s_remain never underflows.
  - cnt is C_SPEED_WIDTH bits; P>>1 is computed in that width.

## Timing
- Start sampled at edge 0:
  - s_busy and m_dir change after edge 0 (cycle 1).
  - First m_drive rise after edge 1 (cycle 2).
- Move length: steps*P cycles of RUN. s_done is asserted in cycle 2+steps*P, and s_busy is 0 in that same cycle.
- A new start is accepted in the s_done cycle.
- m_zpd to s_zpd latency: 2 cycles.
- Async rst forces m_drive = 0 immediately, including mid-pulse.

## Configuration
- FSMOTOR_ZPD_STOP_EN defined:
  - In RUN with latched dir = 0 and s_zpd = 1, the channel behaves as if stop were pending: the current step completes, then s_done fires.
  - s_zhit is set to 1 and held until the next accepted start.
  - Moves with dir = 1 ignore zpd.
- Macro undefined:
  - zpd never affects motion.
  - s_zhit is tied to 0.
  - s_zpd is still provided.

## Test plan
- Ch0, period=4, steps=3, dir=1, start at edge 0:
  - m_dir=1 in cycle 1.
  - m_drive high in cycles 2-3, 6-7 and 10-11.
  - s_remain reads 3, then 2 at cycle 6, 1 at cycle 10, 0 at cycle 14.
  - s_done in cycle 14.
- period=1, steps=2: clamped to P=2; m_drive high in cycles 2 and 4; s_done in cycle 6.
- period=10, steps=100, stop at cycle 23 (mid step 3): pulse train ends after cycle 31, s_done in cycle 32, s_remain=97.
- Macro on, dir=0, steps=50, period=4, m_zpd rises at cycle 20:
  - s_zpd rises at cycle 22.
  - Motion ends after the step in progress: s_done in cycle 26, s_zhit=1, s_remain=44.
- Ch0 and ch5 started on the same edge with different periods: independent trains. A second start on ch0 while busy is ignored.
- rst asserted during an m_drive high phase: m_drive=0, s_busy=0, s_remain=0 immediately. The next start behaves as the first scenario.

Source files
------------

// File: rtl/fsmotor_stepgen_if.sv
// fsmotor_stepgen_if: command/status and driver-pin bundle for fsmotor_stepgen.
// Per-channel buses are flattened; channel i occupies slice i of each bus.
interface fsmotor_stepgen_if #(
  parameter int C_CH_NUM          = 6,
  parameter int C_MICROSTEP_WIDTH = 3,
  parameter int C_STEP_WIDTH      = 16,
  parameter int C_SPEED_WIDTH     = 16
) ();
  logic [C_CH_NUM-1:0]                   s_start;
  logic [C_CH_NUM-1:0]                   s_stop;
  logic [C_CH_NUM-1:0]                   s_dir;
  logic [C_CH_NUM*C_STEP_WIDTH-1:0]      s_steps;
  logic [C_CH_NUM*C_SPEED_WIDTH-1:0]     s_period;
  logic [C_CH_NUM*C_MICROSTEP_WIDTH-1:0] s_ms;
  logic [C_CH_NUM-1:0]                   s_xen;
  logic [C_CH_NUM-1:0]                   s_xrst;
  logic [C_CH_NUM-1:0]                   s_busy;
  logic [C_CH_NUM-1:0]                   s_done;
  logic [C_CH_NUM-1:0]                   s_zhit;
  logic [C_CH_NUM*C_STEP_WIDTH-1:0]      s_remain;
  logic [C_CH_NUM-1:0]                   s_zpd;
  logic [C_CH_NUM-1:0]                   m_zpd;
  logic [C_CH_NUM*C_MICROSTEP_WIDTH-1:0] m_ms;
  logic [C_CH_NUM-1:0]                   m_xen;
  logic [C_CH_NUM-1:0]                   m_xrst;
  logic [C_CH_NUM-1:0]                   m_drive;
  logic [C_CH_NUM-1:0]                   m_dir;

  // Register-file / sensor side: drives commands and the raw sensor, reads status and pins.
  modport master (
    output s_start, s_stop, s_dir, s_steps, s_period, s_ms, s_xen, s_xrst, m_zpd,
    input  s_busy, s_done, s_zhit, s_remain, s_zpd, m_ms, m_xen, m_xrst, m_drive, m_dir
  );

  // Step generator side.
  modport slave (
    input  s_start, s_stop, s_dir, s_steps, s_period, s_ms, s_xen, s_xrst, m_zpd,
    output s_busy, s_done, s_zhit, s_remain, s_zpd, m_ms, m_xen, m_xrst, m_drive, m_dir
  );
endinterface

// File: rtl/fsmotor_stepgen.sv
// fsmotor_stepgen: multi-channel stepper pulse generator.
// Each channel runs an independent IDLE/SETUP/RUN move FSM producing a registered
// drive/dir pulse train. Microstep, enable and driver reset pass straight through.
// Optional feature macro: FSMOTOR_ZPD_STOP_EN -- when defined, a toward-zero move
// ends after the step in progress once the synchronised zero-position detect is seen.
module fsmotor_stepgen #(
  parameter int C_CH_NUM          = 6,
  parameter int C_MICROSTEP_WIDTH = 3,
  parameter int C_STEP_WIDTH      = 16,
  parameter int C_SPEED_WIDTH     = 16,
  parameter int C_INVERT_DIR      = 0
) (
  input  logic             clk,
  input  logic             rst,
  fsmotor_stepgen_if.slave bus_io
);
  localparam int   TW      = C_STEP_WIDTH;
  localparam int   SW      = C_SPEED_WIDTH;
  localparam logic INV_DIR = (C_INVERT_DIR != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_RUN} state_e;

  logic [C_CH_NUM*C_MICROSTEP_WIDTH-1:0] ms_w;
  logic [C_CH_NUM-1:0]                   zpd_meta_q;
  logic [C_CH_NUM-1:0]                   zpd_sync_q;

  assign ms_w          = bus_io.s_ms;
  assign bus_io.m_ms   = ms_w;
  assign bus_io.m_xen  = bus_io.s_xen;
  assign bus_io.m_xrst = bus_io.s_xrst;
  assign bus_io.s_zpd  = zpd_sync_q;

  // Two-flop synchroniser for the asynchronous zero-position sensors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zpd_meta_q <= '0;
      zpd_sync_q <= '0;
    end else begin
      zpd_meta_q <= bus_io.m_zpd;
      zpd_sync_q <= zpd_meta_q;
    end
  end

  for (genvar gi = 0; gi < C_CH_NUM; gi++) begin : g_ch
    state_e        state_q, state_d;
    logic [SW-1:0] period_q, period_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] remain_q, remain_d;
    logic          stop_pend_q, stop_pend_d;
    logic          zpd_pend_q, zpd_pend_d;
    logic          zhit_q, zhit_d;
    logic          done_q, done_d;
    logic          drive_q, drive_d;
    logic          mdir_q, mdir_d;
    logic [SW-1:0] in_period;
    logic [TW-1:0] in_steps;
    logic [SW-1:0] half;
    logic          wrap;
    logic          zpd_now;

    assign in_steps  = bus_io.s_steps[gi*TW +: TW];
    assign in_period = bus_io.s_period[gi*SW +: SW];
    assign half      = period_q >> 1;
    assign wrap      = (cnt_q == period_q - SW'(1));

`ifdef FSMOTOR_ZPD_STOP_EN
    // Logical direction is recovered from the pin register; only toward-zero moves react.
    assign zpd_now = !(mdir_q ^ INV_DIR) && zpd_sync_q[gi];
`else
    assign zpd_now = 1'b0;
`endif

    assign bus_io.s_busy[gi]             = (state_q != ST_IDLE);
    assign bus_io.s_done[gi]             = done_q;
    assign bus_io.s_zhit[gi]             = zhit_q;
    assign bus_io.s_remain[gi*TW +: TW]  = remain_q;
    assign bus_io.m_drive[gi]            = drive_q;
    assign bus_io.m_dir[gi]              = mdir_q;

    // Move FSM next-state: accept/ignore commands, time each step, decide when the move ends.
    always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      cnt_d       = cnt_q;
      remain_d    = remain_q;
      stop_pend_d = stop_pend_q;
      zpd_pend_d  = zpd_pend_q;
      zhit_d      = zhit_q;
      done_d      = 1'b0;
      drive_d     = drive_q;
      mdir_d      = mdir_q;
      case (state_q)
        ST_IDLE: begin
          if (bus_io.s_start[gi] && (in_steps != '0)) begin
            state_d     = ST_SETUP;
            period_d    = (in_period < SW'(2)) ? SW'(2) : in_period;
            remain_d    = in_steps;
            mdir_d      = bus_io.s_dir[gi] ^ INV_DIR;
            cnt_d       = '0;
            drive_d     = 1'b0;
            stop_pend_d = 1'b0;
            zpd_pend_d  = 1'b0;
            zhit_d      = 1'b0;
          end
        end
        ST_SETUP: begin
          if (bus_io.s_stop[gi]) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            // Period is at least 2, so the first half-step is always high.
            state_d = ST_RUN;
            cnt_d   = '0;
            drive_d = 1'b1;
          end
        end
        ST_RUN: begin
          stop_pend_d = stop_pend_q | bus_io.s_stop[gi];
          zpd_pend_d  = zpd_pend_q | zpd_now;
          if (wrap) begin
            remain_d = (remain_q != '0) ? remain_q - TW'(1) : '0;
            cnt_d    = '0;
            if ((remain_d == '0) || stop_pend_d || zpd_pend_d) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              drive_d = 1'b0;
              zhit_d  = zpd_pend_d;
            end else begin
              drive_d = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + SW'(1);
            drive_d = (cnt_d < half);
          end
        end
        default: begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
        end
      endcase
    end

    // Channel state registers; reset parks the pins and clears the status.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q     <= ST_IDLE;
        period_q    <= SW'(2);
        cnt_q       <= '0;
        remain_q    <= '0;
        stop_pend_q <= 1'b0;
        zpd_pend_q  <= 1'b0;
        zhit_q      <= 1'b0;
        done_q      <= 1'b0;
        drive_q     <= 1'b0;
        mdir_q      <= INV_DIR;
      end else begin
        state_q     <= state_d;
        period_q    <= period_d;
        cnt_q       <= cnt_d;
        remain_q    <= remain_d;
        stop_pend_q <= stop_pend_d;
        zpd_pend_q  <= zpd_pend_d;
        zhit_q      <= zhit_d;
        done_q      <= done_d;
        drive_q     <= drive_d;
        mdir_q      <= mdir_d;
      end
    end
  end
endmodule

// File: tb/tb_fsmotor_stepgen.sv
// tb_fsmotor_stepgen: directed and randomized bench for fsmotor_stepgen.
// The reference model describes each move by its start cycle, clamped period and
// number of steps to issue, and derives every output from cycle arithmetic.
module tb_fsmotor_stepgen;
  localparam int N   = 6;
  localparam int MSW = 3;
  localparam int TW  = 16;
  localparam int SW  = 16;
  localparam int INV = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fsmotor_stepgen_if #(.C_CH_NUM(N), .C_MICROSTEP_WIDTH(MSW),
                       .C_STEP_WIDTH(TW), .C_SPEED_WIDTH(SW)) bus ();

  fsmotor_stepgen #(.C_CH_NUM(N), .C_MICROSTEP_WIDTH(MSW), .C_STEP_WIDTH(TW),
                    .C_SPEED_WIDTH(SW), .C_INVERT_DIR(INV)) dut (
    .clk(clk), .rst(rst), .bus_io(bus)
  );

`ifdef FSMOTOR_ZPD_STOP_EN
  localparam bit ZPD_STOP = 1'b1;
`else
  localparam bit ZPD_STOP = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // driven stimulus
  logic [N-1:0] start_v, stop_v, dir_v, zpd_v, xen_v, xrst_v;
  logic [N*MSW-1:0] ms_v;
  int steps_v[N];
  int period_v[N];

  // reference model
  bit act[N];
  int t0[N], per[N], stp[N], nst[N], rem_m[N];
  bit zflag[N], zhit_m[N], mdir_m[N], z1[N], z2[N];

  // observations used by directed checks
  int last_done[N], last_done_rem[N], done_cnt[N];
  bit last_done_zh[N];
  int mask_base, zrise0;
  logic [31:0] drive_mask0;

  task automatic push();
    bus.s_start = start_v;
    bus.s_stop  = stop_v;
    bus.s_dir   = dir_v;
    bus.m_zpd   = zpd_v;
    bus.s_ms    = ms_v;
    bus.s_xen   = xen_v;
    bus.s_xrst  = xrst_v;
    for (int i = 0; i < N; i++) begin
      bus.s_steps[i*TW +: TW]  = TW'(steps_v[i]);
      bus.s_period[i*SW +: SW] = SW'(period_v[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 0; t0[i] = 0; per[i] = 2; stp[i] = 0; nst[i] = 0; rem_m[i] = 0;
      zflag[i] = 0; zhit_m[i] = 0; mdir_m[i] = (INV != 0); z1[i] = 0; z2[i] = 0;
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, step past the rising edge.
  task automatic tick();
    logic [N-1:0] eb, ed, edr, edir, ezh, ezpd;
    logic [N*TW-1:0] erem;
    int k, ph;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      eb[i] = 0; ed[i] = 0; edr[i] = 0;
      erem[i*TW +: TW] = TW'(rem_m[i]);
      if (act[i]) begin
        if (cyc < t0[i]) begin
          eb[i] = 1;
          erem[i*TW +: TW] = TW'(stp[i]);
        end else begin
          k  = (cyc - t0[i]) / per[i];
          ph = (cyc - t0[i]) % per[i];
          if (k < nst[i]) begin
            eb[i]  = 1;
            edr[i] = (ph < per[i] / 2);
            erem[i*TW +: TW] = TW'(stp[i] - k);
          end else begin
            ed[i] = 1;
            erem[i*TW +: TW] = TW'(stp[i] - nst[i]);
          end
        end
      end
      ezh[i]  = ed[i] ? zflag[i] : zhit_m[i];
      edir[i] = mdir_m[i];
      ezpd[i] = z2[i];
    end

    vectors += 10;
    if (bus.s_busy !== eb) begin miscompares++;
      $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.s_busy, eb); end
    if (bus.s_done !== ed) begin miscompares++;
      $display("[TB] FAIL done cyc=%0d got=%b exp=%b", cyc, bus.s_done, ed); end
    if (bus.m_drive !== edr) begin miscompares++;
      $display("[TB] FAIL drive cyc=%0d got=%b exp=%b", cyc, bus.m_drive, edr); end
    if (bus.m_dir !== edir) begin miscompares++;
      $display("[TB] FAIL dir cyc=%0d got=%b exp=%b", cyc, bus.m_dir, edir); end
    if (bus.s_zhit !== ezh) begin miscompares++;
      $display("[TB] FAIL zhit cyc=%0d got=%b exp=%b", cyc, bus.s_zhit, ezh); end
    if (bus.s_zpd !== ezpd) begin miscompares++;
      $display("[TB] FAIL zpd_sync cyc=%0d got=%b exp=%b", cyc, bus.s_zpd, ezpd); end
    if (bus.s_remain !== erem) begin miscompares++;
      $display("[TB] FAIL remain cyc=%0d got=%h exp=%h", cyc, bus.s_remain, erem); end
    if (bus.m_ms !== ms_v) begin miscompares++;
      $display("[TB] FAIL ms_pass cyc=%0d got=%h exp=%h", cyc, bus.m_ms, ms_v); end
    if (bus.m_xen !== xen_v) begin miscompares++;
      $display("[TB] FAIL xen_pass cyc=%0d got=%b exp=%b", cyc, bus.m_xen, xen_v); end
    if (bus.m_xrst !== xrst_v) begin miscompares++;
      $display("[TB] FAIL xrst_pass cyc=%0d got=%b exp=%b", cyc, bus.m_xrst, xrst_v); end

    for (int i = 0; i < N; i++) begin
      if (bus.s_done[i] === 1'b1) begin
        last_done[i]     = cyc;
        last_done_rem[i] = int'(bus.s_remain[i*TW +: TW]);
        last_done_zh[i]  = bus.s_zhit[i];
        done_cnt[i]++;
      end
    end
    if (bus.m_drive[0] === 1'b1 && cyc >= mask_base && cyc - mask_base < 32)
      drive_mask0[cyc - mask_base] = 1'b1;
    if (bus.s_zpd[0] === 1'b1 && zrise0 < 0) zrise0 = cyc;

    for (int i = 0; i < N; i++) begin
      if (act[i] && !ed[i]) begin
        if (cyc < t0[i]) begin
          if (stop_v[i]) nst[i] = 0;
        end else begin
          k = (cyc - t0[i]) / per[i];
          if (stop_v[i] && k + 1 < nst[i]) nst[i] = k + 1;
          if (ZPD_STOP && !dir_of(i) && z2[i]) begin
            zflag[i] = 1;
            if (k + 1 < nst[i]) nst[i] = k + 1;
          end
        end
      end
      if (ed[i]) begin
        act[i]    = 0;
        rem_m[i]  = stp[i] - nst[i];
        zhit_m[i] = zflag[i];
      end
      if (!act[i] && start_v[i] && steps_v[i] != 0) begin
        act[i]    = 1;
        t0[i]     = cyc + 2;
        per[i]    = (period_v[i] < 2) ? 2 : period_v[i];
        stp[i]    = steps_v[i];
        nst[i]    = steps_v[i];
        zflag[i]  = 0;
        zhit_m[i] = 0;
        mdir_m[i] = dir_v[i] ^ (INV != 0);
      end
      z2[i] = z1[i];
      z1[i] = zpd_v[i];
    end

    @(posedge clk);
    #1;
    cyc++;
    start_v = '0;
    stop_v  = '0;
    ms_v    = MSW*N'($urandom);
    xen_v   = N'($urandom);
    xrst_v  = N'($urandom);
    push();
  endtask

  function automatic bit dir_of(int i);
    return mdir_m[i] ^ (INV != 0);
  endfunction

  task automatic wait_idle(int bound);
    bit any;
    for (int n = 0; n < bound; n++) begin
      any = 0;
      for (int i = 0; i < N; i++) if (act[i]) any = 1;
      if (!any && bus.s_busy === '0) return;
      tick();
    end
    vectors++; miscompares++;
    $display("[TB] FAIL idle_timeout cyc=%0d busy=%b exp=0", cyc, bus.s_busy);
  endtask

  task automatic start_ch(int ch, int steps, int period, bit dir);
    start_v[ch] = 1'b1; steps_v[ch] = steps; period_v[ch] = period; dir_v[ch] = dir;
    push();
  endtask

  task automatic test_reset();
    #12;
    vectors += 5;
    if (bus.s_busy !== '0 || bus.s_done !== '0) begin miscompares++;
      $display("[TB] FAIL reset_status got busy=%b done=%b exp=0", bus.s_busy, bus.s_done); end
    if (bus.m_drive !== '0) begin miscompares++;
      $display("[TB] FAIL reset_drive got=%b exp=0", bus.m_drive); end
    if (bus.s_remain !== '0) begin miscompares++;
      $display("[TB] FAIL reset_remain got=%h exp=0", bus.s_remain); end
    if (bus.m_dir !== {N{INV != 0}}) begin miscompares++;
      $display("[TB] FAIL reset_dir got=%b exp=%b", bus.m_dir, {N{INV != 0}}); end
    if (bus.s_zhit !== '0 || bus.s_zpd !== '0) begin miscompares++;
      $display("[TB] FAIL reset_zpd got zhit=%b zpd=%b exp=0", bus.s_zhit, bus.s_zpd); end
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_basic(string tag);
    int cs;
    cs = cyc; mask_base = cs; drive_mask0 = '0; last_done[0] = -1;
    start_ch(0, 3, 4, 1'b1);
    repeat (16) tick();
    vectors += 3;
    if (last_done[0] - cs !== 14) begin miscompares++;
      $display("[TB] FAIL %s_done_cycle got=%0d exp=14", tag, last_done[0] - cs); end
    if (drive_mask0 !== 32'h0000_0CCC) begin miscompares++;
      $display("[TB] FAIL %s_drive_train got=%h exp=00000ccc", tag, drive_mask0); end
    if (last_done_rem[0] !== 0) begin miscompares++;
      $display("[TB] FAIL %s_done_remain got=%0d exp=0", tag, last_done_rem[0]); end
  endtask

  task automatic test_min_period();
    int cs;
    cs = cyc; mask_base = cs; drive_mask0 = '0; last_done[0] = -1;
    start_ch(0, 2, 1, 1'b0);
    repeat (9) tick();
    vectors += 2;
    if (last_done[0] - cs !== 6) begin miscompares++;
      $display("[TB] FAIL minper_done_cycle got=%0d exp=6", last_done[0] - cs); end
    if (drive_mask0 !== 32'h0000_0014) begin miscompares++;
      $display("[TB] FAIL minper_drive_train got=%h exp=00000014", drive_mask0); end
  endtask

  task automatic test_stop();
    int cs;
    cs = cyc; last_done[0] = -1;
    start_ch(0, 100, 10, 1'b1);
    repeat (23) tick();
    stop_v[0] = 1'b1; push();
    repeat (12) tick();
    vectors += 2;
    if (last_done[0] - cs !== 32) begin miscompares++;
      $display("[TB] FAIL stop_done_cycle got=%0d exp=32", last_done[0] - cs); end
    if (last_done_rem[0] !== 97) begin miscompares++;
      $display("[TB] FAIL stop_remain got=%0d exp=97", last_done_rem[0]); end
  endtask

  task automatic test_setup_stop();
    int cs;
    cs = cyc; last_done[4] = -1;
    start_ch(4, 7, 3, 1'b1);
    tick();
    stop_v[4] = 1'b1; push();
    repeat (4) tick();
    vectors += 2;
    if (last_done[4] - cs !== 2) begin miscompares++;
      $display("[TB] FAIL setup_stop_done got=%0d exp=2", last_done[4] - cs); end
    if (last_done_rem[4] !== 7) begin miscompares++;
      $display("[TB] FAIL setup_stop_remain got=%0d exp=7", last_done_rem[4]); end
  endtask

  task automatic test_zero_steps();
    last_done[3] = -1;
    start_ch(3, 0, 3, 1'b1);
    stop_v[3] = 1'b1; push();
    repeat (5) tick();
    vectors++;
    if (last_done[3] !== -1) begin miscompares++;
      $display("[TB] FAIL zero_steps_done got=%0d exp=-1", last_done[3]); end
  endtask

  task automatic test_back_to_back();
    int cs;
    cs = cyc; done_cnt[2] = 0;
    start_ch(2, 1, 2, 1'b1);
    repeat (4) tick();
    start_ch(2, 1, 3, 1'b0);
    repeat (7) tick();
    vectors += 2;
    if (last_done[2] - cs !== 9) begin miscompares++;
      $display("[TB] FAIL b2b_done_cycle got=%0d exp=9", last_done[2] - cs); end
    if (done_cnt[2] !== 2) begin miscompares++;
      $display("[TB] FAIL b2b_done_count got=%0d exp=2", done_cnt[2]); end
  endtask

  task automatic test_multi();
    int cs;
    cs = cyc; done_cnt[0] = 0;
    start_ch(0, 4, 3, 1'b1);
    start_ch(5, 3, 5, 1'b0);
    repeat (4) tick();
    start_ch(0, 9, 2, 1'b0);
    repeat (16) tick();
    vectors += 3;
    if (last_done[0] - cs !== 14) begin miscompares++;
      $display("[TB] FAIL multi_ch0_done got=%0d exp=14", last_done[0] - cs); end
    if (last_done[5] - cs !== 17) begin miscompares++;
      $display("[TB] FAIL multi_ch5_done got=%0d exp=17", last_done[5] - cs); end
    if (done_cnt[0] !== 1) begin miscompares++;
      $display("[TB] FAIL multi_busy_start got=%0d dones exp=1", done_cnt[0]); end
  endtask

  task automatic test_zpd();
    int cs;
    cs = cyc; last_done[0] = -1; zrise0 = -1;
    start_ch(0, 50, 4, 1'b0);
    repeat (20) tick();
    zpd_v[0] = 1'b1; push();
    repeat (8) tick();
    wait_idle(400);
    tick();
    zpd_v[0] = 1'b0; push();
    repeat (3) tick();
    vectors += 4;
    if (zrise0 - cs !== 22) begin miscompares++;
      $display("[TB] FAIL zpd_latency got=%0d exp=22", zrise0 - cs); end
`ifdef FSMOTOR_ZPD_STOP_EN
    if (last_done[0] - cs !== 26) begin miscompares++;
      $display("[TB] FAIL zpd_done_cycle got=%0d exp=26", last_done[0] - cs); end
    if (last_done_rem[0] !== 44) begin miscompares++;
      $display("[TB] FAIL zpd_remain got=%0d exp=44", last_done_rem[0]); end
    if (last_done_zh[0] !== 1'b1) begin miscompares++;
      $display("[TB] FAIL zpd_zhit got=%b exp=1", last_done_zh[0]); end
`else
    if (last_done[0] - cs !== 202) begin miscompares++;
      $display("[TB] FAIL zpd_done_cycle got=%0d exp=202", last_done[0] - cs); end
    if (last_done_rem[0] !== 0) begin miscompares++;
      $display("[TB] FAIL zpd_remain got=%0d exp=0", last_done_rem[0]); end
    if (last_done_zh[0] !== 1'b0) begin miscompares++;
      $display("[TB] FAIL zpd_zhit got=%b exp=0", last_done_zh[0]); end
`endif
  endtask

  task automatic test_reset_mid();
    start_ch(0, 3, 4, 1'b1);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    vectors += 3;
    if (bus.m_drive[0] !== 1'b0) begin miscompares++;
      $display("[TB] FAIL midrst_drive got=%b exp=0", bus.m_drive[0]); end
    if (bus.s_busy !== '0) begin miscompares++;
      $display("[TB] FAIL midrst_busy got=%b exp=0", bus.s_busy); end
    if (bus.s_remain !== '0) begin miscompares++;
      $display("[TB] FAIL midrst_remain got=%h exp=0", bus.s_remain); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc++;
    test_basic("after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 700; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          start_v[i]  = 1'b1;
          steps_v[i]  = int'($urandom_range(0, 6));
          period_v[i] = int'($urandom_range(0, 6));
          dir_v[i]    = 1'($urandom);
        end
        if ($urandom_range(0, 19) == 0) stop_v[i] = 1'b1;
        if ($urandom_range(0, 9) == 0) zpd_v[i] = ~zpd_v[i];
      end
      push();
      tick();
    end
    zpd_v = '0; push();
    wait_idle(200);
    repeat (3) tick();
  endtask

  initial begin
    start_v = '0; stop_v = '0; dir_v = '0; zpd_v = '0; xen_v = '0; xrst_v = '0; ms_v = '0;
    for (int i = 0; i < N; i++) begin
      steps_v[i] = 0; period_v[i] = 0; last_done[i] = -1; last_done_rem[i] = 0;
      last_done_zh[i] = 0; done_cnt[i] = 0;
    end
    mask_base = 0; zrise0 = -1; drive_mask0 = '0;
    model_reset();
    push();
    test_reset();
    tick();
    test_basic("basic");
    wait_idle(100);
    test_min_period();
    wait_idle(100);
    test_stop();
    wait_idle(100);
    test_setup_stop();
    wait_idle(100);
    test_zero_steps();
    test_back_to_back();
    wait_idle(100);
    test_multi();
    wait_idle(100);
    test_zpd();
    wait_idle(100);
    test_reset_mid();
    wait_idle(100);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
